beam_accumulator: RTL and testbench
===================================

# beam_accumulator

Sums the per-element weighted samples produced by the complex multiplier stage into one beamformed output sample per snapshot. Elements arrive serially, one per valid cycle, as 18-bit signed I/Q in the same fixed-point format the multiplier emits. After N_ELEM elements are accepted, the block outputs the saturated 18-bit complex sum to the downstream beam output / weight-update logic.

## Interface
- N_ELEM, 4: antenna elements per snapshot; 2..16.
- W, 18: sample width of I and Q, both inputs and outputs.
- ACC_W, 23: accumulator width; must be at least W + ceil(log2(N_ELEM)); the default covers N_ELEM up to 32.

- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_I/in_Q carry one element's weighted sample this cycle.
- in_sync  in  1  marks this cycle's sample as element 0 of a snapshot; realigns the element counter.
- in_I  in  W  signed real part of the weighted element sample.
- in_Q  in  W  signed imaginary part of the weighted element sample.
- out_valid  out  1  one-cycle pulse; out_I/out_Q/out_sat are valid.
- out_I  out  W  signed saturated beam sum, real part.
- out_Q  out  W  signed saturated beam sum, imaginary part.
- out_sat  out  1  set with out_valid when either component clipped.
- elem_idx  out  ceil(log2(N_ELEM))  index of the next element expected.

## Operation
- Registers:
  - acc_I, acc_Q: ACC_W-bit signed accumulators.
  - cnt: element counter, 0..N_ELEM-1.
  - Registered outputs.
- Reset, synchronous: acc_I = acc_Q = 0, cnt = 0, out_valid = 0, out_I = out_Q = 0, out_sat = 0, elem_idx = 0.
- When in_valid is 0, accumulators and counter hold.
- Accepted sample with in_sync=1, or with cnt=0:
  - Accumulator loads the sign-extended input; it does not add to the old contents.
  - cnt becomes 1.
- Accepted sample with 0<cnt<N_ELEM-1: accumulator += sign-extended input; cnt increments.
- Accepted sample with cnt=N_ELEM-1 (last element):
  - The final sum is acc + input, computed at full ACC_W width.
  - The final sum is saturated to W bits and registered to out_I/out_Q.
  - out_valid is asserted for one cycle.
  - cnt wraps to 0.
  - The accumulator contents become don't-care; the next accepted sample loads.
- in_sync with in_valid=0 is ignored.
- in_sync on a sample when cnt≠0:
  - The partial snapshot is discarded and no output is produced.
  - The sample becomes element 0.
- in_sync when N_ELEM=... and cnt=N_ELEM-1: sync wins. The sample is element 0 and no output is produced.
- Saturation, per component:
  - If the sum > 2^(W-1)-1, the output is 2^(W-1)-1 (131071 for W=18).
  - If the sum < -2^(W-1), the output is -2^(W-1) (-131072).
  - Otherwise the output is the low W bits of the sum.
  - No rounding or shifting: the scale is identical to the input scale.
- out_sat = clip_I OR clip_Q. It is registered alongside out_I/out_Q and cleared whenever out_valid is 0.
- out_I/out_Q hold their last value between pulses.
- elem_idx = cnt at all times.

## Timing
- No backpressure: a sample is accepted on every cycle in which in_valid=1.
- Back-to-back snapshots at the full rate of 1 sample/cycle are supported with no bubble.
- Latency: out_valid rises in the cycle after the clock edge that accepts the last element. The result is registered exactly 1 cycle after the last sample.
- Gaps (in_valid=0) within a snapshot are allowed and have any length; they do not affect the result.
- rst asserted mid-snapshot:
  - The next edge clears all state.
  - An out_valid that is due on that edge is suppressed.
  - A sample presented with rst high is dropped.
- The critical path is one ACC_W adder followed by a saturation compare. There are no other pipeline stages.

## Test plan
- Nominal sum, N_ELEM=4: four valid samples of (1000, -2000), first with in_sync=1 -> one out_valid pulse 1 cycle after the 4th sample with out_I=4000, out_Q=-8000, out_sat=0.
- Saturation: four samples of (100000, -100000) -> out_I=131071, out_Q=-131072, out_sat=1. The next snapshot of four samples of (1, 1) -> (4, 4), out_sat=0.
- Gapped input: samples (10,0), (20,0), (30,0), (40,0), each separated by 3 idle cycles -> out_I=100, out_Q=0. out_valid stays low during the gaps. elem_idx steps 1, 2, 3, 0.
- Continuous stream: 3 back-to-back snapshots of 12 consecutive samples with values k=1..12 for I and -k for Q -> out_valid on cycles 4, 8, 12 after start with I = 10, 26, 42 and Q = -10, -26, -42.
- Resync: 2 samples of (500, 500), then an in_sync sample starting a new snapshot of 4 samples of (7, -7) -> no output for the partial snapshot, then a single output (28, -28).
- Reset mid-snapshot: 3 samples of (1000, 1000), rst high for 1 cycle, then 4 samples of (1, 2) -> all outputs 0 during reset, then a single output (4, 8). No pulse is produced from the pre-reset samples.

Source files
------------

// File: rtl/beam_accumulator.sv
// beam_accumulator
// ----------------
// Sums one snapshot of N_ELEM weighted element samples (complex, signed W-bit
// I/Q) into one beamformed output sample. The sum is saturated back to W bits
// at the input scale. There is no rounding and no shift.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_I/in_Q carry one element sample this cycle
//   in_sync    this cycle's sample is element 0 (realigns the counter)
//   in_I/in_Q  signed weighted element sample, W bits each
//   out_valid  one-cycle pulse: out_I/out_Q/out_sat are valid
//   out_I/Q    signed saturated beam sum; holds between pulses
//   out_sat    either component clipped (only with out_valid)
//   elem_idx   index of the next element expected (equals the counter)
module beam_accumulator #(
  parameter int N_ELEM = 4,
  parameter int W      = 18,
  parameter int ACC_W  = 23,
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sync,
  input  logic signed [W-1:0] in_I,
  input  logic signed [W-1:0] in_Q,
  output logic                out_valid,
  output logic signed [W-1:0] out_I,
  output logic signed [W-1:0] out_Q,
  output logic                out_sat,
  output logic [IDX_W-1:0]    elem_idx
);

  localparam logic signed [ACC_W-1:0] sat_max = ACC_W'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] sat_min = -sat_max - ACC_W'(1);
  localparam logic [IDX_W-1:0]        last_idx = IDX_W'(N_ELEM - 1);

  logic signed [ACC_W-1:0] acc_I, acc_Q;
  logic [IDX_W-1:0]        cnt;

  logic signed [ACC_W-1:0] ext_I, ext_Q;
  logic signed [ACC_W-1:0] sum_I, sum_Q;
  logic signed [W-1:0]     sat_I, sat_Q;
  logic                    clip_I, clip_Q;
  logic                    start_elem, last_elem;

  assign ext_I = ACC_W'(in_I);
  assign ext_Q = ACC_W'(in_Q);
  assign sum_I = acc_I + ext_I;
  assign sum_Q = acc_Q + ext_Q;

  // A sync always restarts the snapshot, even on what would have been the
  // last element, so sync takes priority over completion.
  assign start_elem = in_sync || (cnt == '0);
  assign last_elem  = !start_elem && (cnt == last_idx);

  // Single-adder, single-compare saturation of the full-width sum.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sat_I  = sum_I[W-1:0];
    sat_Q  = sum_Q[W-1:0];
    clip_I = 1'b0;
    clip_Q = 1'b0;
    if (sum_I > sat_max) begin
      sat_I  = sat_max[W-1:0];
      clip_I = 1'b1;
    end else if (sum_I < sat_min) begin
      sat_I  = sat_min[W-1:0];
      clip_I = 1'b1;
    end
    if (sum_Q > sat_max) begin
      sat_Q  = sat_max[W-1:0];
      clip_Q = 1'b1;
    end else if (sum_Q < sat_min) begin
      sat_Q  = sat_min[W-1:0];
      clip_Q = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_I     <= '0;
      acc_Q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_I     <= '0;
      out_Q     <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      if (in_valid) begin
        if (start_elem) begin
          // Load rather than add: discards any partial snapshot.
          acc_I <= ext_I;
          acc_Q <= ext_Q;
          cnt   <= IDX_W'(1);
        end else if (last_elem) begin
          // Accumulator is left stale; the next accepted sample loads it.
          out_I     <= sat_I;
          out_Q     <= sat_Q;
          out_sat   <= clip_I || clip_Q;
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          acc_I <= sum_I;
          acc_Q <= sum_Q;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

  assign elem_idx = cnt;

endmodule

// File: tb/tb_beam_accumulator.sv
// Directed bench for beam_accumulator with the default N_ELEM=4, W=18.
module tb_beam_accumulator;

  localparam int W = 18;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_sync;
  logic signed [W-1:0] in_I;
  logic signed [W-1:0] in_Q;
  logic                out_valid;
  logic signed [W-1:0] out_I;
  logic signed [W-1:0] out_Q;
  logic                out_sat;
  logic [1:0]          elem_idx;

  int vectors     = 0;
  int miscompares = 0;

  beam_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_I     (in_I),
    .in_Q     (in_Q),
    .out_valid(out_valid),
    .out_I    (out_I),
    .out_Q    (out_Q),
    .out_sat  (out_sat),
    .elem_idx (elem_idx)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sync, input int i_val, input int q_val);
    in_valid = 1'b1;
    in_sync  = sync;
    in_I     = W'(i_val);
    in_Q     = W'(q_val);
    step();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sync = 1'b0;
    in_I = '0;
    in_Q = '0;
    step();
    step();
    vectors++;
    if ({out_valid, out_sat, out_I, out_Q, elem_idx} !== {1'b0, 1'b0, 18'sd0, 18'sd0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset: got v=%0b s=%0b I=%0d Q=%0d idx=%0d, want all zero",
               out_valid, out_sat, out_I, out_Q, elem_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    for (int k = 0; k < 3; k++) begin
      send(k == 0, 1000, -2000);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL nominal_early[%0d]: out_valid=%0b want 0", k, out_valid);
      end
    end
    send(1'b0, 1000, -2000);
    vectors++;
    if ({out_valid, out_sat, out_I, out_Q, elem_idx} !== {1'b1, 1'b0, 18'sd4000, -18'sd8000, 2'd0}) begin
      miscompares++;
      $display("FAIL nominal: got v=%0b s=%0b I=%0d Q=%0d idx=%0d, want v=1 s=0 I=4000 Q=-8000 idx=0",
               out_valid, out_sat, out_I, out_Q, elem_idx);
    end
    idle(1);
    vectors++;
    if ({out_valid, out_I, out_Q} !== {1'b0, 18'sd4000, -18'sd8000}) begin
      miscompares++;
      $display("FAIL nominal_hold: got v=%0b I=%0d Q=%0d, want v=0 I=4000 Q=-8000",
               out_valid, out_I, out_Q);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) send(k == 0, 100000, -100000);
    vectors++;
    if ({out_valid, out_sat, out_I, out_Q} !== {1'b1, 1'b1, 18'sd131071, -18'sd131072}) begin
      miscompares++;
      $display("FAIL saturate: got v=%0b s=%0b I=%0d Q=%0d, want v=1 s=1 I=131071 Q=-131072",
               out_valid, out_sat, out_I, out_Q);
    end
    idle(1);
    vectors++;
    if ({out_valid, out_sat} !== 2'b00) begin
      miscompares++;
      $display("FAIL sat_clear: got v=%0b s=%0b, want 0 0", out_valid, out_sat);
    end
    for (int k = 0; k < 4; k++) send(1'b0, 1, 1);
    vectors++;
    if ({out_valid, out_sat, out_I, out_Q} !== {1'b1, 1'b0, 18'sd4, 18'sd4}) begin
      miscompares++;
      $display("FAIL after_sat: got v=%0b s=%0b I=%0d Q=%0d, want v=1 s=0 I=4 Q=4",
               out_valid, out_sat, out_I, out_Q);
    end
  endtask

  task automatic test_gapped();
    logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       gap_pulse;
    for (int k = 0; k < 4; k++) begin
      send(k == 0, 10 * (k + 1), 0);
      vectors++;
      if (elem_idx !== exp_idx[k]) begin
        miscompares++;
        $display("FAIL gap_idx[%0d]: got %0d want %0d", k, elem_idx, exp_idx[k]);
      end
      if (k == 3) begin
        vectors++;
        if ({out_valid, out_sat, out_I, out_Q} !== {1'b1, 1'b0, 18'sd100, 18'sd0}) begin
          miscompares++;
          $display("FAIL gapped: got v=%0b s=%0b I=%0d Q=%0d, want v=1 s=0 I=100 Q=0",
                   out_valid, out_sat, out_I, out_Q);
        end
      end
      gap_pulse = 1'b0;
      for (int g = 0; g < 3; g++) begin
        idle(1);
        gap_pulse |= out_valid;
      end
      vectors++;
      if (gap_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_quiet[%0d]: out_valid seen=%0b want 0", k, gap_pulse);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_sum;
    exp_sum = 0;
    for (int k = 1; k <= 12; k++) begin
      send(k == 1, k, -k);
      exp_sum += k;
      vectors++;
      if (k % 4 == 0) begin
        if ({out_valid, out_sat, out_I, out_Q} !== {1'b1, 1'b0, W'(exp_sum), W'(-exp_sum)}) begin
          miscompares++;
          $display("FAIL stream[%0d]: got v=%0b s=%0b I=%0d Q=%0d, want v=1 s=0 I=%0d Q=%0d",
                   k, out_valid, out_sat, out_I, out_Q, exp_sum, -exp_sum);
        end
        exp_sum = 0;
      end else if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_gap[%0d]: out_valid=%0b want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_resync();
    logic pulse;
    pulse = 1'b0;
    send(1'b1, 500, 500);
    pulse |= out_valid;
    send(1'b0, 500, 500);
    pulse |= out_valid;
    send(1'b1, 7, -7);
    pulse |= out_valid;
    vectors++;
    if (elem_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL resync_idx: got %0d want 1", elem_idx);
    end
    for (int k = 0; k < 2; k++) begin
      send(1'b0, 7, -7);
      pulse |= out_valid;
    end
    vectors++;
    if (pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_partial: out_valid seen=%0b want 0", pulse);
    end
    send(1'b0, 7, -7);
    vectors++;
    if ({out_valid, out_I, out_Q} !== {1'b1, 18'sd28, -18'sd28}) begin
      miscompares++;
      $display("FAIL resync: got v=%0b I=%0d Q=%0d, want v=1 I=28 Q=-28", out_valid, out_I, out_Q);
    end
    // Sync on the would-be last element restarts instead of completing.
    for (int k = 0; k < 3; k++) send(k == 0, 3, 3);
    send(1'b1, 3, 3);
    vectors++;
    if ({out_valid, elem_idx} !== {1'b0, 2'd1}) begin
      miscompares++;
      $display("FAIL sync_on_last: got v=%0b idx=%0d, want v=0 idx=1", out_valid, elem_idx);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic pulse;
    for (int k = 0; k < 3; k++) send(k == 0, 1000, 1000);
    // The fourth element arrives together with rst: dropped, pulse suppressed.
    rst = 1'b1;
    send(1'b0, 1000, 1000);
    rst = 1'b0;
    vectors++;
    if ({out_valid, out_sat, out_I, out_Q, elem_idx} !== {1'b0, 1'b0, 18'sd0, 18'sd0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%0b s=%0b I=%0d Q=%0d idx=%0d, want all zero",
               out_valid, out_sat, out_I, out_Q, elem_idx);
    end
    pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(1'b0, 1, 2);
      pulse |= out_valid;
    end
    vectors++;
    if (pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stale: out_valid seen=%0b want 0", pulse);
    end
    send(1'b0, 1, 2);
    vectors++;
    if ({out_valid, out_sat, out_I, out_Q} !== {1'b1, 1'b0, 18'sd4, 18'sd8}) begin
      miscompares++;
      $display("FAIL after_reset: got v=%0b s=%0b I=%0d Q=%0d, want v=1 s=0 I=4 Q=8",
               out_valid, out_sat, out_I, out_Q);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_gapped();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
